// File: rtl/csa_seq_pkg.sv
// csa_seq_pkg: shared FSM state type and sizing helper for the sliced sequential adder.
package csa_seq_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   function automatic int idx_width(input int nslice);
      return $clog2(nslice);
   endfunction
endpackage

// File: rtl/csa_seq_ctrl_csa.sv
// CSA: carry-select adder built from sizeRCA-bit ripple blocks, each precomputed for carry 0 and 1.
module CSA #(
   parameter int sizeCSA = 24,
   parameter int sizeRCA = 4
) (
   input  logic [sizeCSA-1:0] a,
   input  logic [sizeCSA-1:0] b,
   input  logic               cin,
   output logic [sizeCSA-1:0] sum,
   output logic               cout
);
   localparam int NB = sizeCSA / sizeRCA;
   logic [NB:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < NB; i++) begin : g_blk
      logic [sizeRCA:0] s0, s1;
      assign s0 = {1'b0, a[i*sizeRCA +: sizeRCA]} + {1'b0, b[i*sizeRCA +: sizeRCA]};
      assign s1 = {1'b0, a[i*sizeRCA +: sizeRCA]} + {1'b0, b[i*sizeRCA +: sizeRCA]} + (sizeRCA+1)'(1);
      assign sum[i*sizeRCA +: sizeRCA] = c[i] ? s1[sizeRCA-1:0] : s0[sizeRCA-1:0];
      assign c[i+1] = c[i] ? s1[sizeRCA] : s0[sizeRCA];
   end
   assign cout = c[NB];
endmodule

// File: rtl/csa_seq_ctrl.sv
// csa_seq_ctrl: WIDTH-bit sum from one SLICE-bit CSA reused per slice, LSB first, carry held between passes.
// Define CSA_SEQ_EARLY_EXIT_EN to finish once remaining operand slices and the slice carry are all zero.
module csa_seq_ctrl
   import csa_seq_pkg::*;
#(
   parameter int WIDTH = 48,
   parameter int SLICE = 24,
   parameter int RCA   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW = idx_width(NSLICE);
   if (NSLICE < 2 || WIDTH % SLICE != 0) begin : g_bad_cfg
      $error("csa_seq_ctrl: WIDTH must be a multiple of SLICE with at least two slices");
   end
   state_t state, next_state;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic [IW-1:0] idx;
   logic carry_q, cout_q, slice_cout, early, finish;
   logic [SLICE-1:0] slice_sum;
   CSA #(.sizeCSA(SLICE), .sizeRCA(RCA)) u_csa (
      .a(a_q[SLICE-1:0]), .b(b_q[SLICE-1:0]), .cin(carry_q), .sum(slice_sum), .cout(slice_cout)
   );
`ifdef CSA_SEQ_EARLY_EXIT_EN
   assign early = ~|a_q[WIDTH-1:SLICE] & ~|b_q[WIDTH-1:SLICE] & ~slice_cout;
`else
   assign early = 1'b0;
`endif
   assign finish = (idx == IW'(NSLICE-1)) | early;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= next_state;
   end
   always_comb begin
      next_state = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (finish ? DONE : RUN) :
                   state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
   end
   always_comb begin
      in_ready  = rst_n && state == IDLE;
      out_valid = state == DONE;
      busy      = state != IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         sum_q <= '0;
         idx <= '0;
         carry_q <= 1'b0;
         cout_q <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_q <= in_a;
         b_q <= in_b;
         sum_q <= '0;
         idx <= '0;
         carry_q <= in_cin;
         cout_q <= 1'b0;
      end else if (state == RUN) begin
         sum_q[idx*SLICE +: SLICE] <= slice_sum;
         carry_q <= slice_cout;
         a_q <= a_q >> SLICE;
         b_q <= b_q >> SLICE;
         idx <= idx + 1'b1;
         if (finish) cout_q <= slice_cout;
      end
   end
   assign out_sum  = sum_q;
   assign out_cout = cout_q;
endmodule

// File: tb/tb_csa_seq_ctrl.sv
// tb_csa_seq_ctrl: directed-vector bench for the sliced sequential adder.
module tb_csa_seq_ctrl;
   logic clk = 0, rst_n = 0, in_valid = 0, in_cin = 0, out_ready = 0;
   logic [47:0] in_a = '0, in_b = '0;
   logic in_ready, out_valid, out_cout, busy;
   logic [47:0] out_sum;
   int checks = 0, failures = 0;
`ifdef CSA_SEQ_EARLY_EXIT_EN
   localparam int SMALL_LAT = 1;
`else
   localparam int SMALL_LAT = 2;
`endif

   csa_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one operand set from IDLE and waits for out_valid; lat=-1 on timeout.
   task automatic do_op(input logic [47:0] a, input logic [47:0] b, input logic c, output int lat);
      in_a = a; in_b = b; in_cin = c; in_valid = 1;
      tick();
      in_valid = 0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic release_result();
      out_ready = 1;
      tick();
      out_ready = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags out_valid=%b busy=%b exp=0/0", out_valid, busy); end
      checks++; if (out_sum !== 48'h0 || out_cout !== 1'b0) begin failures++; $display("FAIL reset_result sum=%h cout=%b exp=0/0", out_sum, out_cout); end
      rst_n = 1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_carry();
      int lat;
      do_op(48'h000000FFFFFF, 48'h000000000001, 1'b0, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL carry_latency got=%0d exp=2", lat); end
      checks++; if (out_sum !== 48'h000001000000 || out_cout !== 1'b0) begin failures++; $display("FAIL carry_result sum=%h cout=%b exp=000001000000/0", out_sum, out_cout); end
      release_result();
   endtask

   task automatic test_wrap();
      int lat;
      do_op(48'hFFFFFFFFFFFF, 48'h0, 1'b1, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL wrap_latency got=%0d exp=2", lat); end
      checks++; if (out_sum !== 48'h0 || out_cout !== 1'b1) begin failures++; $display("FAIL wrap_result sum=%h cout=%b exp=000000000000/1", out_sum, out_cout); end
      release_result();
   endtask

   task automatic test_backpressure();
      int lat;
      do_op(48'h111111111111, 48'h0123456789AB, 1'b0, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL bp_latency got=%0d exp=2", lat); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 48'h123456789ABC || out_cout !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d valid=%b ready=%b sum=%h cout=%b exp=1/0/123456789abc/0", i, out_valid, in_ready, out_sum, out_cout);
         end
         tick();
      end
      release_result();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release valid=%b busy=%b ready=%b exp=0/0/1", out_valid, busy, in_ready); end
   endtask

   task automatic test_early_exit();
      int lat;
      do_op(48'd5, 48'd7, 1'b0, lat);
      checks++; if (lat !== SMALL_LAT) begin failures++; $display("FAIL early_latency got=%0d exp=%0d", lat, SMALL_LAT); end
      checks++; if (out_sum !== 48'd12 || out_cout !== 1'b0) begin failures++; $display("FAIL early_result sum=%h cout=%b exp=00000000000c/0", out_sum, out_cout); end
      release_result();
   endtask

   task automatic test_reset_mid();
      int lat;
      in_a = 48'h800000000000; in_b = 48'h800000000000; in_cin = 0; in_valid = 1;
      tick();
      in_valid = 0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
      rst_n = 0;
      tick();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 48'h0) begin failures++; $display("FAIL mid_reset valid=%b busy=%b sum=%h exp=0/0/0", out_valid, busy, out_sum); end
      rst_n = 1;
      #1;
      do_op(48'd1, 48'd2, 1'b0, lat);
      checks++; if (lat !== SMALL_LAT || out_sum !== 48'd3 || out_cout !== 1'b0) begin failures++; $display("FAIL mid_next lat=%0d sum=%h cout=%b exp=%0d/3/0", lat, out_sum, out_cout, SMALL_LAT); end
      release_result();
   endtask

   task automatic test_back_to_back();
      int c = 0, acc2 = -1, nres = 0;
      logic drop = 0;
      out_ready = 1;
      in_a = 48'h000000FFFFFF; in_b = 48'h000000FFFFFF; in_cin = 1; in_valid = 1;
      tick();
      in_a = 48'h800000000000; in_b = 48'h800000000000; in_cin = 0;
      while (nres < 2 && c < 30) begin
         tick();
         c++;
         if (drop) in_valid = 0;
         if (in_ready && in_valid && acc2 < 0) begin acc2 = c + 1; drop = 1; end
         if (out_valid) begin
            nres++;
            checks++;
            if (nres == 1 && (out_sum !== 48'h000001FFFFFF || out_cout !== 1'b0)) begin failures++; $display("FAIL b2b_first sum=%h cout=%b exp=000001ffffff/0", out_sum, out_cout); end
            if (nres == 2 && (out_sum !== 48'h0 || out_cout !== 1'b1)) begin failures++; $display("FAIL b2b_second sum=%h cout=%b exp=000000000000/1", out_sum, out_cout); end
         end
      end
      in_valid = 0;
      out_ready = 0;
      checks++; if (nres !== 2) begin failures++; $display("FAIL b2b_results got=%0d exp=2", nres); end
      checks++; if (acc2 !== 4) begin failures++; $display("FAIL b2b_interval got=%0d exp=4", acc2); end
      tick();
   endtask

   initial begin
      test_reset();
      test_carry();
      test_wrap();
      test_backpressure();
      test_early_exit();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
